// File: rtl/gs_frame_buffer_pkg.sv
// Shared constants, state encodings and address helpers for the grayscale
// frame buffer and its per-chain RAMs.
package gs_frame_buffer_pkg;

    localparam int GS_BITS      = 12;
    localparam int CHANS        = 48;
    localparam int ROWS         = 6;
    localparam int CHAINS       = 12;
    localparam int BITS_PER_ROW = CHANS * GS_BITS;
    localparam int RAM_AW       = 10;
    localparam int CLR_DEPTH    = 1 << RAM_AW;

    localparam int CHAIN_W = 4;
    localparam int ROW_W   = 3;
    localparam int CHAN_W  = 6;
    localparam int FETCH_W = CHAN_W + 1;

    // Chain numbering: left chains 1..6 then right chains 1..6.
    localparam logic [CHAIN_W-1:0] CHAIN_L1 = 4'd0;
    localparam logic [CHAIN_W-1:0] CHAIN_L6 = 4'd5;
    localparam logic [CHAIN_W-1:0] CHAIN_R1 = 4'd6;
    localparam logic [CHAIN_W-1:0] CHAIN_R6 = 4'd11;

    localparam logic [CHAIN_W-1:0] CHAIN_LIMIT = CHAIN_W'(CHAINS);
    localparam logic [ROW_W-1:0]   ROW_LIMIT   = ROW_W'(ROWS);
    localparam logic [CHAN_W-1:0]  CHAN_LIMIT  = CHAN_W'(CHANS);
    localparam logic [CHAN_W-1:0]  LAST_CHAN   = CHAN_W'(CHANS - 1);
    localparam logic [3:0]         LAST_BIT    = 4'(GS_BITS - 1);
    localparam logic [FETCH_W-1:0] FETCH_DONE  = FETCH_W'(CHANS);
    localparam logic [RAM_AW-1:0]  CLR_LAST    = RAM_AW'(CLR_DEPTH - 1);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        PENDING
    } fb_state_e;

    // Where the word returned by the RAM on the next cycle should land.
    typedef enum logic [1:0] {
        DST_NONE,
        DST_SHIFT,
        DST_PREFETCH
    } rd_dst_e;

    function automatic logic [RAM_AW-1:0] ram_addr(input logic              bank,
                                                   input logic [ROW_W-1:0]  row,
                                                   input logic [CHAN_W-1:0] chan);
        return {bank, row, chan};
    endfunction

    function automatic logic beat_in_range(input logic [CHAIN_W-1:0] chain,
                                           input logic [ROW_W-1:0]   row,
                                           input logic [CHAN_W-1:0]  chan);
        return (chain < CHAIN_LIMIT) && (row < ROW_LIMIT) && (chan < CHAN_LIMIT);
    endfunction

endpackage

// File: rtl/gs_frame_buffer_if.sv
// Pixel write port, commit/row-read controls and LED serial outputs of the
// frame buffer. The master side drives pixels and serializer strobes.
interface gs_frame_buffer_if;
    import gs_frame_buffer_pkg::*;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [CHAIN_W-1:0]   pix_chain;
    logic [ROW_W-1:0]     pix_row;
    logic [CHAN_W-1:0]    pix_chan;
    logic [GS_BITS-1:0]   pix_data;
    logic                 frame_commit;
    logic                 commit_pending;
    logic                 rd_row_start;
    logic [ROW_W-1:0]     rd_row;
    logic                 rd_advance;
    logic [6:1]           led_l_sin;
    logic [6:1]           led_r_sin;
    logic                 front_bank;
    logic                 drop_flag;

    modport master (
        output pix_valid, pix_chain, pix_row, pix_chan, pix_data,
        output frame_commit, rd_row_start, rd_row, rd_advance,
        input  pix_ready, commit_pending, led_l_sin, led_r_sin,
        input  front_bank, drop_flag
    );

    modport slave (
        input  pix_valid, pix_chain, pix_row, pix_chan, pix_data,
        input  frame_commit, rd_row_start, rd_row, rd_advance,
        output pix_ready, commit_pending, led_l_sin, led_r_sin,
        output front_bank, drop_flag
    );
endinterface

// File: rtl/gs_chain_ram.sv
// One chain's grayscale store: 1024 x 12, one write port and one read port
// with a registered read (maps onto a single block RAM).
module gs_chain_ram
    import gs_frame_buffer_pkg::*;
(
    input  logic               clock,
    input  logic               we_i,
    input  logic [RAM_AW-1:0]  waddr_i,
    input  logic [GS_BITS-1:0] wdata_i,
    input  logic [RAM_AW-1:0]  raddr_i,
    output logic [GS_BITS-1:0] rdata_o
);

    logic [GS_BITS-1:0] mem_q [CLR_DEPTH];

    // Synchronous write and registered read; contents are not reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/gs_frame_buffer.sv
// Double-buffered grayscale frame store feeding 12 LED serial chains.
// Pixels are written into the back bank; the serializer reads the front bank
// one row at a time, MSB first, one bit per rd_advance. Banks swap only when
// a pending commit meets a row-0 start, so a displayed frame never tears.
module gs_frame_buffer
    import gs_frame_buffer_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    gs_frame_buffer_if.slave   bus
);

    // Control FSM and bank bookkeeping.
    fb_state_e          state_q, state_d;
    logic [RAM_AW-1:0]  clr_addr_q, clr_addr_d;
    logic               front_bank_q, front_bank_d;
    logic               drop_flag_q, drop_flag_d;
    logic               init_we;
    logic               wr_en;
    logic               pix_ready;
    logic               swap_now;
    logic               row_start;
    logic               start_bank;

    // Row read sequencer, shared by all chains.
    logic [ROW_W-1:0]   row_q, row_d;
    logic               bank_q, bank_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [3:0]         bit_q, bit_d;
    logic [FETCH_W-1:0] fetch_chan_q, fetch_chan_d;
    logic               shift_valid_q, shift_valid_d;
    rd_dst_e            dst_q, dst_d;
    logic               issue_bank;
    logic [ROW_W-1:0]   issue_row;
    logic [CHAN_W-1:0]  issue_chan;
    logic               load_shift_ram;
    logic               load_shift_pref;
    logic               load_pref;
    logic               shift_en;

    // RAM port signals common to all chains.
    logic [RAM_AW-1:0]  waddr;
    logic [GS_BITS-1:0] wdata;
    logic [RAM_AW-1:0]  raddr;
    logic [CHAINS-1:0]  serial;

    // Row starts are only honoured once the RAMs have been cleared.
    assign row_start  = bus.rd_row_start && (state_q != INIT);
    assign start_bank = front_bank_q ^ swap_now;

    // FSM next state: clear sweep, write acceptance, commit and bank swap.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        front_bank_d = front_bank_q;
        drop_flag_d  = drop_flag_q;
        init_we      = 1'b0;
        wr_en        = 1'b0;
        pix_ready    = 1'b0;
        swap_now     = 1'b0;
        case (state_q)
            INIT: begin
                init_we    = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                pix_ready = 1'b1;
                if (bus.pix_valid) begin
                    if (beat_in_range(bus.pix_chain, bus.pix_row, bus.pix_chan)) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_flag_d = 1'b1;
                    end
                end
                if (bus.frame_commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (row_start && (bus.rd_row == '0)) begin
                    swap_now     = 1'b1;
                    front_bank_d = ~front_bank_q;
                    state_d      = RUN;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= INIT;
            clr_addr_q   <= '0;
            front_bank_q <= 1'b0;
            drop_flag_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            front_bank_q <= front_bank_d;
            drop_flag_q  <= drop_flag_d;
        end
    end

    // Read sequencer: start/restart a row, prime shift and prefetch words,
    // then shift on each advance and pull the next channel every 12 bits.
    always_comb begin
        row_d           = row_q;
        bank_d          = bank_q;
        chan_d          = chan_q;
        bit_d           = bit_q;
        fetch_chan_d    = fetch_chan_q;
        shift_valid_d   = shift_valid_q;
        dst_d           = DST_NONE;
        issue_bank      = bank_q;
        issue_row       = row_q;
        issue_chan      = fetch_chan_q[CHAN_W-1:0];
        load_shift_ram  = 1'b0;
        load_shift_pref = 1'b0;
        load_pref       = 1'b0;
        shift_en        = 1'b0;
        if (row_start) begin
            row_d         = bus.rd_row;
            bank_d        = start_bank;
            chan_d        = '0;
            bit_d         = LAST_BIT;
            shift_valid_d = 1'b0;
            issue_bank    = start_bank;
            issue_row     = bus.rd_row;
            issue_chan    = '0;
            if (bus.rd_row < ROW_LIMIT) begin
                dst_d        = DST_SHIFT;
                fetch_chan_d = FETCH_W'(1);
            end else begin
                // Phantom row: nothing fetched, outputs stay 0.
                fetch_chan_d = FETCH_DONE;
            end
        end else begin
            load_pref = (dst_q == DST_PREFETCH);
            if (dst_q == DST_SHIFT) begin
                load_shift_ram = 1'b1;
                shift_valid_d  = 1'b1;
                dst_d          = DST_PREFETCH;
                fetch_chan_d   = fetch_chan_q + 1'b1;
            end else if (bus.rd_advance && shift_valid_q) begin
                if (bit_q != '0) begin
                    shift_en = 1'b1;
                    bit_d    = bit_q - 1'b1;
                end else if (chan_q == LAST_CHAN) begin
                    shift_valid_d = 1'b0;
                end else begin
                    load_shift_pref = 1'b1;
                    chan_d          = chan_q + 1'b1;
                    bit_d           = LAST_BIT;
                    if (fetch_chan_q < FETCH_DONE) begin
                        dst_d        = DST_PREFETCH;
                        fetch_chan_d = fetch_chan_q + 1'b1;
                    end
                end
            end
        end
    end

    // Read sequencer registers; reset drops the outputs immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_q         <= '0;
            bank_q        <= 1'b0;
            chan_q        <= '0;
            bit_q         <= LAST_BIT;
            fetch_chan_q  <= FETCH_DONE;
            shift_valid_q <= 1'b0;
            dst_q         <= DST_NONE;
        end else begin
            row_q         <= row_d;
            bank_q        <= bank_d;
            chan_q        <= chan_d;
            bit_q         <= bit_d;
            fetch_chan_q  <= fetch_chan_d;
            shift_valid_q <= shift_valid_d;
            dst_q         <= dst_d;
        end
    end

    // The clear sweep owns the write port during INIT; otherwise pixels go
    // to the bank that is not on display.
    assign waddr = init_we ? clr_addr_q
                           : ram_addr(~front_bank_q, bus.pix_row, bus.pix_chan);
    assign wdata = init_we ? '0 : bus.pix_data;
    assign raddr = ram_addr(issue_bank, issue_row, issue_chan);

    genvar gi;
    generate
        for (gi = 0; gi < CHAINS; gi++) begin : g_chain
            logic               we;
            logic [GS_BITS-1:0] rdata;
            logic [GS_BITS-1:0] shift_q, shift_d;
            logic [GS_BITS-1:0] pref_q, pref_d;

            assign we = init_we | (wr_en & (bus.pix_chain == CHAIN_W'(gi)));

            gs_chain_ram u_ram (
                .clock   (clock),
                .we_i    (we),
                .waddr_i (waddr),
                .wdata_i (wdata),
                .raddr_i (raddr),
                .rdata_o (rdata)
            );

            // Shift word: loaded from RAM at row start, from prefetch at a
            // channel boundary, otherwise shifted MSB-first on advance.
            always_comb begin
                shift_d = shift_q;
                pref_d  = pref_q;
                if (load_shift_ram) begin
                    shift_d = rdata;
                end else if (load_shift_pref) begin
                    shift_d = pref_q;
                end else if (shift_en) begin
                    shift_d = {shift_q[GS_BITS-2:0], 1'b0};
                end
                if (load_pref) begin
                    pref_d = rdata;
                end
            end

            // Per-chain shift and prefetch registers.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    shift_q <= '0;
                    pref_q  <= '0;
                end else begin
                    shift_q <= shift_d;
                    pref_q  <= pref_d;
                end
            end

            assign serial[gi] = shift_valid_q & shift_q[GS_BITS-1];
        end
    endgenerate

    assign bus.led_l_sin      = serial[CHAIN_L6:CHAIN_L1];
    assign bus.led_r_sin      = serial[CHAIN_R6:CHAIN_R1];
    assign bus.pix_ready      = pix_ready;
    assign bus.commit_pending = (state_q == PENDING);
    assign bus.front_bank     = front_bank_q;
    assign bus.drop_flag      = drop_flag_q;

endmodule
